alu_pipe: RTL and testbench



---
 rtl/alu_pipe.sv | 157 +++++++++++++++
 tb/tb_alu_pipe.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage handshaked ALU.
// S1 latches the operands and opcode; S2 holds the registered result and flags.
// An internal carry register (cy) chains ADC/SBB onto the previous arithmetic op.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       CTR,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] O,
  output logic [3:0]       FLAGS
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready, and a producer holds its payload
  // stable while valid is high and ready is low.

  localparam int unsigned WU = WIDTH;
  localparam logic [WIDTH-1:0] WIDTH_L = WIDTH'(WU);
  localparam int MSB = WIDTH - 1;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] ina_q, ina_d;
  logic [WIDTH-1:0] inb_q, inb_d;
  logic [3:0]       ctr_q, ctr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic [3:0]       flags_q, flags_d;
  logic             cy_q, cy_d;

  logic             advance;
  logic             accept;
  logic             move;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;
  logic             is_arith;

  // Flow control: S1 may refill whenever S2 can take its current contents.
  always_comb begin
    advance  = !out_valid_q || out_ready;
    in_ready = !s1_valid_q || advance;
    accept   = in_valid && in_ready;
    move     = s1_valid_q && advance;
  end

  // Datapath: compute the result and flags of the operation waiting in S1.
  always_comb begin
    sum      = '0;
    res      = '0;
    res_c    = 1'b0;
    res_v    = 1'b0;
    is_arith = (ctr_q[3:2] == 2'b00);
    case (ctr_q)
      4'b0000: begin
        sum   = {1'b0, ina_q} + {1'b0, inb_q};
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (ina_q[MSB] == inb_q[MSB]) && (res[MSB] != ina_q[MSB]);
      end
      4'b0001: begin
        sum   = {1'b0, ina_q} - {1'b0, inb_q};
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (ina_q[MSB] != inb_q[MSB]) && (res[MSB] != ina_q[MSB]);
      end
      4'b0010: begin
        sum   = {1'b0, ina_q} + {1'b0, inb_q} + {{WIDTH{1'b0}}, cy_q};
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (ina_q[MSB] == inb_q[MSB]) && (res[MSB] != ina_q[MSB]);
      end
      4'b0011: begin
        // Bit WIDTH of the extended difference is the borrow, even at A=0,B=max,cy=1.
        sum   = {1'b0, ina_q} - {1'b0, inb_q} - {{WIDTH{1'b0}}, cy_q};
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (ina_q[MSB] != inb_q[MSB]) && (res[MSB] != ina_q[MSB]);
      end
      4'b1000: res = ina_q & inb_q;
      4'b1001: res = ina_q | inb_q;
      4'b1010: res = ina_q ^ inb_q;
      4'b1011: res = ~ina_q;
      4'b1100: res = (inb_q >= WIDTH_L) ? '0 : (ina_q >> inb_q);
      4'b1101: res = (inb_q >= WIDTH_L) ? '0 : (ina_q << inb_q);
      4'b1110: res = {ina_q[0], ina_q[WIDTH-1:1]};
      4'b1111: res = {ina_q[WIDTH-2:0], ina_q[WIDTH-1]};
      default: res = '0;
    endcase
  end

  // Next-state: S1 load, S1->S2 move, S2 drain and carry update.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    ina_d       = ina_q;
    inb_d       = inb_q;
    ctr_d       = ctr_q;
    out_valid_d = out_valid_q;
    o_d         = o_q;
    flags_d     = flags_q;
    cy_d        = cy_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      ina_d      = A;
      inb_d      = B;
      ctr_d      = CTR;
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end

    if (move) begin
      out_valid_d = 1'b1;
      o_d         = res;
      flags_d     = {res[MSB], (res == '0), res_c, res_v};
      if (is_arith) cy_d = res_c;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset that discards anything in flight.
  always_ff @(posedge ck) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      ina_q       <= '0;
      inb_q       <= '0;
      ctr_q       <= '0;
      out_valid_q <= 1'b0;
      o_q         <= '0;
      flags_q     <= '0;
      cy_q        <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      ina_q       <= ina_d;
      inb_q       <= inb_d;
      ctr_q       <= ctr_d;
      out_valid_q <= out_valid_d;
      o_q         <= o_d;
      flags_q     <= flags_d;
      cy_q        <= cy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign O         = o_q;
  assign FLAGS     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table, hand sequences for back-to-back carry,
// backpressure and mid-flight reset, then randomized traffic against a model.
module tb_alu_pipe;

  localparam int W = 8;

  // Clock and reset
  logic         ck = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [3:0]   CTR = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] O;
  logic [3:0]   FLAGS;

  always #5 ck = ~ck;

  alu_pipe #(.WIDTH(W)) dut (
    .ck(ck), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .CTR(CTR),
    .out_valid(out_valid), .out_ready(out_ready),
    .O(O), .FLAGS(FLAGS)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  bit mon_en  = 1'b0;
  bit rand_bp = 1'b0;
  bit m_cy    = 1'b0;
  logic [W-1:0] last_o = '0;
  logic [W+3:0] exp_q[$];

  typedef struct {
    logic [3:0]   ctr;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] o;
    logic [3:0]   f;
  } vec_t;
  vec_t vt[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode rules.
  function automatic logic [W+3:0] model(input logic [3:0] c, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    int m  = 1 << W;
    int ia = int'(a);
    int ib = int'(b);
    int sa = a[W-1] ? ia - m : ia;
    int sb = b[W-1] ? ib - m : ib;
    int s  = 0;
    int ss = 0;
    int ci = m_cy ? 1 : 0;
    bit cf = 1'b0;
    bit vf = 1'b0;
    logic [W-1:0] o;
    case (c)
      4'd0:  begin s = ia + ib;      cf = (s >= m);  ss = sa + sb;      end
      4'd1:  begin s = ia - ib;      cf = (ia < ib); ss = sa - sb;      end
      4'd2:  begin s = ia + ib + ci; cf = (s >= m);  ss = sa + sb + ci; end
      4'd3:  begin s = ia - ib - ci; cf = (s < 0);   ss = sa - sb - ci; end
      4'd8:  s = ia & ib;
      4'd9:  s = ia | ib;
      4'd10: s = ia ^ ib;
      4'd11: s = (m - 1) - ia;
      4'd12: s = (ib >= W) ? 0 : (ia >> ib);
      4'd13: s = (ib >= W) ? 0 : ((ia << ib) % m);
      4'd14: s = (ia >> 1) + ((ia % 2) << (W - 1));
      4'd15: s = ((ia * 2) % m) + (ia >> (W - 1));
      default: s = 0;
    endcase
    o = s[W-1:0];
    if (c < 4) begin
      vf   = (ss > (m / 2 - 1)) || (ss < -(m / 2));
      m_cy = cf;
    end
    return {o, o[W-1], (o == '0), cf, vf};
  endfunction

  // Driver: present one op starting at a falling edge, hold it until accepted.
  task automatic send(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    bit got = 1'b0;
    A = a; B = b; CTR = c; in_valid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      #1 got = in_ready;
      @(posedge ck);
      @(negedge ck);
      if (got) break;
    end
    in_valid = 1'b0;
    if (got) exp_q.push_back(model(c, a, b));
    else chk("send_timeout", 32'(got), 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge ck);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge ck);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mon_en = 1'b0;
    repeat (2) @(negedge ck);
    rst = 1'b0;
    exp_q.delete();
    m_cy = 1'b0;
  endtask

  // Directed vector: single op into an idle pipe, exact two-edge latency.
  task automatic run_vec(input int i);
    A = vt[i].a; B = vt[i].b; CTR = vt[i].ctr; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("vec_in_ready", in_ready, 1);
    @(posedge ck); @(negedge ck);
    in_valid = 1'b0;
    #1 chk("vec_not_early", out_valid, 0);
    @(posedge ck); @(negedge ck);
    #1;
    chk("vec_out_valid", out_valid, 1);
    chk($sformatf("vec%0d_o", i), O, vt[i].o);
    chk($sformatf("vec%0d_flags", i), FLAGS, vt[i].f);
  endtask

  // Random backpressure on the consumer side.
  initial forever begin
    @(negedge ck);
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  end

  // Scoreboard: compare every accepted result against the expected queue.
  initial forever begin
    logic [W+3:0] e;
    @(negedge ck);
    #2;
    if (mon_en && !rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL extra_result: got %0h expected none", O);
      end else begin
        e = exp_q.pop_front();
        chk("sb_o", O, e[W+3:4]);
        chk("sb_flags", FLAGS, e[3:0]);
      end
      last_o = O;
      n_out++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] o_hold;

    vt[0]  = '{4'h0, 8'hFF, 8'h01, 8'h00, 4'b0110};
    vt[1]  = '{4'h2, 8'h00, 8'h00, 8'h01, 4'b0000};
    vt[2]  = '{4'h3, 8'h00, 8'h00, 8'h00, 4'b0100};
    vt[3]  = '{4'h0, 8'h7F, 8'h01, 8'h80, 4'b1001};
    vt[4]  = '{4'h1, 8'h10, 8'h20, 8'hF0, 4'b1010};
    vt[5]  = '{4'hC, 8'h81, 8'h01, 8'h40, 4'b0000};
    vt[6]  = '{4'hD, 8'h81, 8'h03, 8'h08, 4'b0000};
    vt[7]  = '{4'hC, 8'h81, 8'h09, 8'h00, 4'b0100};
    vt[8]  = '{4'hE, 8'h81, 8'h00, 8'hC0, 4'b1000};
    vt[9]  = '{4'hF, 8'h81, 8'h00, 8'h03, 4'b0000};
    vt[10] = '{4'h5, 8'h81, 8'h01, 8'h00, 4'b0100};
    vt[11] = '{4'h2, 8'h01, 8'h01, 8'h03, 4'b0000};
    vt[12] = '{4'h8, 8'hF0, 8'h3C, 8'h30, 4'b0000};
    vt[13] = '{4'h9, 8'hF0, 8'h0F, 8'hFF, 4'b1000};
    vt[14] = '{4'hA, 8'hAA, 8'hAA, 8'h00, 4'b0100};
    vt[15] = '{4'hB, 8'h5A, 8'h00, 8'hA5, 4'b1000};
    vt[16] = '{4'h1, 8'h00, 8'h01, 8'hFF, 4'b1010};
    vt[17] = '{4'h3, 8'h05, 8'h02, 8'h02, 4'b0000};
    vt[18] = '{4'hD, 8'h01, 8'h07, 8'h80, 4'b1000};
    vt[19] = '{4'hD, 8'h01, 8'h08, 8'h00, 4'b0100};

    // Reset state
    do_reset();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_o", O, 0);
    chk("rst_flags", FLAGS, 0);
    @(negedge ck);

    // Directed table
    for (int i = 0; i < 20; i++) run_vec(i);

    // Back-to-back ADD then ADC sees the carry of its predecessor
    do_reset();
    A = 8'hFF; B = 8'h01; CTR = 4'h0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge ck); @(negedge ck);
    A = 8'h00; B = 8'h00; CTR = 4'h2;
    #1 chk("b2b_in_ready", in_ready, 1);
    @(posedge ck); @(negedge ck);
    in_valid = 1'b0;
    #1;
    chk("b2b_first_o", O, 8'h00);
    chk("b2b_first_flags", FLAGS, 4'b0110);
    @(posedge ck); @(negedge ck);
    #1;
    chk("b2b_second_valid", out_valid, 1);
    chk("b2b_second_o", O, 8'h01);
    chk("b2b_second_flags", FLAGS, 4'b0000);
    @(posedge ck); @(negedge ck);
    #1 chk("b2b_drained", out_valid, 0);

    // Backpressure: two accepts fill the pipe, then it stalls with O stable
    do_reset();
    mon_en = 1'b1; n_out = 0;
    send(4'h0, 8'h10, 8'h01);
    send(4'h0, 8'h20, 8'h02);
    A = 8'h30; B = 8'h03; CTR = 4'h0; in_valid = 1'b1;
    #1;
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_first_o", O, 8'h11);
    o_hold = O;
    for (int k = 0; k < 3; k++) begin
      @(negedge ck);
      #1;
      chk("bp_stall_ready", in_ready, 0);
      chk("bp_stall_o", O, o_hold);
    end
    @(negedge ck);
    out_ready = 1'b1;
    send(4'h0, 8'h30, 8'h03);
    send(4'h0, 8'h40, 8'h04);
    drain();
    chk("bp_result_count", n_out, 4);

    // Reset with both stages full and cy = 1
    do_reset();
    send(4'h0, 8'hFF, 8'h01);
    send(4'h0, 8'h01, 8'h01);
    #1 chk("rstmid_full", {30'd0, out_valid, in_ready}, 32'b10);
    @(negedge ck);
    rst = 1'b1;
    @(negedge ck);
    rst = 1'b0;
    #1;
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_in_ready", in_ready, 1);
    chk("rstmid_o", O, 0);
    chk("rstmid_flags", FLAGS, 0);
    exp_q.delete();
    m_cy = 1'b0;
    @(negedge ck);
    mon_en = 1'b1; out_ready = 1'b1;
    send(4'h2, 8'h01, 8'h01);
    drain();
    chk("rstmid_adc_o", last_o, 8'h02);

    // Randomized traffic with random gaps and random backpressure
    do_reset();
    mon_en = 1'b1; rand_bp = 1'b1; n_out = 0;
    for (int i = 0; i < 300; i++) begin
      logic [3:0]   c;
      logic [W-1:0] a, b;
      if ($urandom_range(0, 3) == 0) @(negedge ck);
      c = 4'($urandom_range(0, 15));
      a = W'($urandom);
      b = W'($urandom);
      if (c >= 4'hC && $urandom_range(0, 1) == 1) b = W'($urandom_range(0, W + 1));
      send(c, a, b);
    end
    rand_bp = 1'b0;
    @(negedge ck);
    out_ready = 1'b1;
    drain();
    chk("rand_result_count", n_out, 300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
